store_pack_unit: RTL and testbench
==================================

Name: store_pack_unit

Overview:
- Store-side narrowing counterpart to the immediate/load extenders in the M stage.
- Takes a 32-bit register value plus a store type (SW/SH/SB) and packs it into byte-lane write data and byte enables.
- Checks address alignment and legality; on a violation it raises AdES instead of issuing a request.
- Drives a req/ack handshake toward the bridge (DM + timers), with an ack timeout, and stalls the pipeline while a store is outstanding.

Parameters:
- TIMEOUT, 15: cycles `mem_req` may stay high without `mem_ack` before the request is abandoned with `bus_err`.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- st_valid  in  1  M-stage store request.
- st_type  in  2  00 SW, 01 SH, 10 SB, 11 reserved.
- st_addr  in  32  byte address.
- st_data  in  32  rt register value.
- st_ready  out  1  unit idle and able to accept.
- stall  out  1  st_valid & ~st_ready (combinational).
- exc_ades  out  1  one-cycle store address-error pulse.
- mem_req  out  1  write request to bridge.
- mem_addr  out  32  registered st_addr, low 2 bits forced to 0.
- mem_wdata  out  32  lane-replicated write data.
- mem_byteen  out  4  byte enables.
- mem_ack  in  1  bridge completion.
- bus_err  out  1  one-cycle timeout pulse.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, timeout counter=0.
  - mem_req, exc_ades and bus_err = 0.
  - mem_addr, mem_wdata and mem_byteen = 0.
  - st_ready=1.
  - Reset while in REQ abandons the request: mem_req is 0 after that edge and no bus_err pulse is generated.
- States are IDLE and REQ. st_ready = (state==IDLE).
- Accept: st_valid & st_ready sampled at edge N.
  - Illegal request: exc_ades=1 during cycle N+1 only; state stays IDLE; no mem_req.
  - Legal request: state→REQ at edge N. mem_req, mem_addr, mem_wdata and mem_byteen are registered and valid from cycle N+1.
- Illegal conditions, any one sufficient:
  - st_type==11.
  - SW with st_addr[1:0]≠0.
  - SH with st_addr[0]≠0.
  - Address outside 0x0000_0000–0x0000_2FFF, 0x0000_7F00–0x0000_7F0B and 0x0000_7F10–0x0000_7F1B.
  - SH or SB to either timer range.
  - Any store to 0x7F08 or 0x7F18 (timer COUNT, read-only).
- Packing:
  - SW: byteen=1111, wdata=st_data.
  - SH: byteen=0011 if addr[1]=0, else 1100; wdata={2{st_data[15:0]}}.
  - SB: byteen=0001<<addr[1:0]; wdata={4{st_data[7:0]}}.
- REQ state:
  - Outputs are held stable, and st_data/st_addr changes are ignored.
  - mem_ack sampled high at an edge: state→IDLE, mem_req→0, byteen→0. An ack in the very first REQ cycle is legal, giving minimum occupancy of 1 cycle.
  - Counter increments each REQ cycle without ack. When the counter reaches TIMEOUT (without ack): bus_err=1 for the next cycle, state→IDLE, counter→0.
  - Ack and timeout in the same cycle: ack wins, no bus_err.
- mem_ack while IDLE is ignored.
- New accept: a new store can be accepted in the first IDLE cycle after completion. No back-to-back accept in the ack cycle itself (st_ready is still 0 then).
- Counter width is ≥ clog2(TIMEOUT+1). The counter saturates and does not wrap.

Test Plan:
- SW 0x1234_5678 to 0x0000_0104, ack on 2nd REQ cycle:
  - mem_req high cycles N+1..N+2.
  - mem_addr=0x104, byteen=1111, wdata=0x12345678.
  - st_ready high again at N+3.
- SB 0xAABB_CCDD to 0x0000_0203, immediate ack:
  - byteen=1000, wdata=0xDDDDDDDD, mem_addr=0x200.
  - Single-cycle REQ.
- SH to 0x0000_0102 with data 0x0000_BEEF: byteen=1100, wdata=0xBEEFBEEF.
- Illegal requests (each case → exc_ades pulse at N+1, no mem_req, st_ready stays 1):
  - SW to 0x0000_0102.
  - SH to 0x0000_7F04.
  - SW to 0x0000_7F08.
  - SW to 0x0000_3000.
- No ack for TIMEOUT=15 cycles: bus_err pulses once, mem_req drops, st_ready=1 next cycle.
  - Repeat with ack arriving on the 15th cycle: no bus_err.
- Drive reset=0 during the 3rd REQ cycle: all outputs 0 and st_ready=1 after that edge. A late mem_ack afterward is ignored.

Source files
------------

// File: rtl/store_pack_unit.sv
// -----------------------------------------------------------------------------
// store_pack_unit
//
// Store-side narrowing unit for the M stage. A 32-bit register value plus a
// store type (SW/SH/SB) is packed into lane-replicated write data and byte
// enables. The address is checked for alignment and against the legal store
// map. Illegal stores raise a one-cycle AdES pulse instead of a bus request.
// Legal stores are issued to the bridge over a req/ack handshake that has an
// ack timeout. The pipeline is stalled while a store is outstanding.
//
// Handshake: the M stage offers a store with st_valid. The store is taken at
// a rising edge where st_valid & st_ready are both 1. Toward the bridge,
// mem_req is held high with stable addr/wdata/byteen until an edge samples
// mem_ack high. A request that sees no ack for TIMEOUT cycles is abandoned
// with a one-cycle bus_err pulse. mem_ack is ignored while no request is
// pending.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-low
//   st_valid    M-stage store request
//   st_type     00 SW, 01 SH, 10 SB, 11 reserved
//   st_addr     byte address
//   st_data     rt register value
//   st_ready    unit idle and able to accept
//   stall       st_valid & ~st_ready (combinational)
//   exc_ades    one-cycle store address-error pulse
//   mem_req     write request to bridge
//   mem_addr    word address of the request (low 2 bits zero)
//   mem_wdata   lane-replicated write data
//   mem_byteen  byte enables
//   mem_ack     bridge completion
//   bus_err     one-cycle ack-timeout pulse
// -----------------------------------------------------------------------------
module store_pack_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        stall,
    output logic        exc_ades,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic        mem_ack,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Count value seen during the last permitted REQ cycle.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    localparam logic [1:0] T_SW = 2'b00;
    localparam logic [1:0] T_SH = 2'b01;
    localparam logic [1:0] T_SB = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic          req_n;
    logic [31:0]   addr_n;
    logic [31:0]   wdata_n;
    logic [3:0]    byteen_n;
    logic          ades_n;
    logic          berr_n;

    // ------------------------------------------------------------------
    // Legality of the offered store
    // ------------------------------------------------------------------
    logic in_dm, in_tmr0, in_tmr1, in_tmr, is_count;
    logic misaligned, legal;

    always_comb begin
        in_dm    = (st_addr <= 32'h0000_2FFF);
        in_tmr0  = (st_addr >= 32'h0000_7F00) && (st_addr <= 32'h0000_7F0B);
        in_tmr1  = (st_addr >= 32'h0000_7F10) && (st_addr <= 32'h0000_7F1B);
        in_tmr   = in_tmr0 | in_tmr1;
        // Timer COUNT registers are read-only.
        is_count = (st_addr == 32'h0000_7F08) || (st_addr == 32'h0000_7F18);

        misaligned = 1'b0;
        case (st_type)
            T_SW:    misaligned = (st_addr[1:0] != 2'b00);
            T_SH:    misaligned = st_addr[0];
            default: misaligned = 1'b0;
        endcase

        legal = (st_type != 2'b11)
              & ~misaligned
              & (in_dm | in_tmr)
              // Timers only accept full-word stores.
              & ~(in_tmr & (st_type != T_SW))
              & ~is_count;
    end

    // ------------------------------------------------------------------
    // Lane packing
    // ------------------------------------------------------------------
    logic [3:0]  pack_be;
    logic [31:0] pack_wd;

    always_comb begin
        pack_be = 4'b0000;
        pack_wd = st_data;
        case (st_type)
            T_SW: begin
                pack_be = 4'b1111;
                pack_wd = st_data;
            end
            T_SH: begin
                pack_be = st_addr[1] ? 4'b1100 : 4'b0011;
                pack_wd = {2{st_data[15:0]}};
            end
            T_SB: begin
                pack_be = 4'b0001 << st_addr[1:0];
                pack_wd = {4{st_data[7:0]}};
            end
            default: begin
                pack_be = 4'b0000;
                pack_wd = st_data;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state and registered-output next values
    // ------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        req_n    = mem_req;
        addr_n   = mem_addr;
        wdata_n  = mem_wdata;
        byteen_n = mem_byteen;
        ades_n   = 1'b0;
        berr_n   = 1'b0;

        case (state)
            IDLE: begin
                if (st_valid) begin
                    if (legal) begin
                        state_n  = REQ;
                        cnt_n    = '0;
                        req_n    = 1'b1;
                        addr_n   = {st_addr[31:2], 2'b00};
                        wdata_n  = pack_wd;
                        byteen_n = pack_be;
                    end else begin
                        ades_n = 1'b1;
                    end
                end
            end
            REQ: begin
                // Ack has priority over a timeout in the same cycle.
                if (mem_ack) begin
                    state_n  = IDLE;
                    cnt_n    = '0;
                    req_n    = 1'b0;
                    byteen_n = 4'b0000;
                end else if (cnt >= CNT_LAST) begin
                    state_n  = IDLE;
                    cnt_n    = '0;
                    req_n    = 1'b0;
                    byteen_n = 4'b0000;
                    berr_n   = 1'b1;
                end else begin
                    // Saturating increment; never wraps back to zero.
                    cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_byteen <= 4'b0000;
            exc_ades   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            mem_req    <= req_n;
            mem_addr   <= addr_n;
            mem_wdata  <= wdata_n;
            mem_byteen <= byteen_n;
            exc_ades   <= ades_n;
            bus_err    <= berr_n;
        end
    end

    assign st_ready = (state == IDLE);
    assign stall    = st_valid & ~st_ready;

endmodule

// File: tb/tb_store_pack_unit.sv
// -----------------------------------------------------------------------------
// tb_store_pack_unit
//
// Directed bench for store_pack_unit. A behavioural model tracks what the
// outputs must be from the store rules (address map, lane arithmetic, request
// age), and a compare process checks every output against it on each falling
// edge. Directed sequences also check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_store_pack_unit;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        stall;
    logic        exc_ades;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic        mem_ack;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    store_pack_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_type    (st_type),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .stall      (stall),
        .exc_ades   (exc_ades),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_byteen (mem_byteen),
        .mem_ack    (mem_ack),
        .bus_err    (bus_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid = 0;
    bit          m_busy;
    int          m_age;      // 1-based index of the current request cycle
    bit          m_req, m_ades, m_berr;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;

    function automatic int size_of(input logic [1:0] t);
        return (t == 2'd0) ? 4 : (t == 2'd1) ? 2 : 1;
    endfunction

    function automatic bit store_ok(input logic [1:0] t, input logic [31:0] a);
        bit dm, tmr;
        int sz;
        if (t == 2'd3) return 0;
        sz  = size_of(t);
        dm  = (a < 32'h3000);
        tmr = (a >= 32'h7F00 && a < 32'h7F0C) || (a >= 32'h7F10 && a < 32'h7F1C);
        if ((a % sz) != 0) return 0;
        if (!(dm || tmr)) return 0;
        if (tmr && sz != 4) return 0;
        if (a == 32'h7F08 || a == 32'h7F18) return 0;
        return 1;
    endfunction

    always @(posedge clk) begin
        int sz, off;
        if (!reset) begin
            m_valid = 1;
            m_busy  = 0;
            m_age   = 0;
            m_req   = 0;
            m_ades  = 0;
            m_berr  = 0;
            m_addr  = 0;
            m_wdata = 0;
            m_be    = 0;
        end else if (m_valid) begin
            m_ades = 0;
            m_berr = 0;
            if (!m_busy) begin
                if (st_valid) begin
                    if (store_ok(st_type, st_addr)) begin
                        sz  = size_of(st_type);
                        off = st_addr % 4;
                        m_busy = 1;
                        m_age  = 1;
                        m_req  = 1;
                        m_addr = st_addr - off;
                        for (int b = 0; b < 4; b++) begin
                            m_be[b] = (b >= off) && (b < off + sz);
                            m_wdata[8*b +: 8] = st_data[8*(b % sz) +: 8];
                        end
                    end else begin
                        m_ades = 1;
                    end
                end
            end else if (mem_ack) begin
                m_busy = 0;
                m_req  = 0;
                m_be   = 0;
            end else if (m_age == TIMEOUT) begin
                m_busy = 0;
                m_req  = 0;
                m_be   = 0;
                m_berr = 1;
            end else begin
                m_age++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid && reset) begin
            chk("st_ready",   {31'b0, st_ready},   {31'b0, !m_busy});
            chk("stall",      {31'b0, stall},      {31'b0, st_valid && m_busy});
            chk("exc_ades",   {31'b0, exc_ades},   {31'b0, m_ades});
            chk("bus_err",    {31'b0, bus_err},    {31'b0, m_berr});
            chk("mem_req",    {31'b0, mem_req},    {31'b0, m_req});
            chk("mem_addr",   mem_addr,            m_addr);
            chk("mem_wdata",  mem_wdata,           m_wdata);
            chk("mem_byteen", {28'b0, mem_byteen}, {28'b0, m_be});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Offer one store for one cycle; returns in the cycle after acceptance.
    task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_type  = t;
        st_addr  = a;
        st_data  = d;
        tick();
        st_valid = 1'b0;
        st_data  = 32'hDEAD_BEEF;
        st_addr  = 32'hFFFF_FFFC;
    endtask

    task automatic ack_after(input int lat);
        for (int k = 0; k < lat; k++) tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        bit          ok;
        logic [3:0]  be;
    } vec_t;

    vec_t vecs[12];

    // ---------------- directed stimulus ----------------
    initial begin
        reset    = 1'b0;
        st_valid = 1'b0;
        st_type  = 2'b00;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        mem_ack  = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // Reset state
        at_neg();
        chk("rst_ready",  {31'b0, st_ready}, 32'd1);
        chk("rst_req",    {31'b0, mem_req},  32'd0);
        chk("rst_addr",   mem_addr,          32'd0);
        chk("rst_wdata",  mem_wdata,         32'd0);
        chk("rst_byteen", {28'b0, mem_byteen}, 32'd0);
        tick();

        // SW 0x12345678 -> 0x104, ack in 2nd request cycle
        issue(2'b00, 32'h0000_0104, 32'h1234_5678);
        at_neg();
        chk("sw_req1",   {31'b0, mem_req},     32'd1);
        chk("sw_addr",   mem_addr,             32'h0000_0104);
        chk("sw_be",     {28'b0, mem_byteen},  32'hF);
        chk("sw_wdata",  mem_wdata,            32'h1234_5678);
        chk("sw_ready0", {31'b0, st_ready},    32'd0);
        tick();
        mem_ack = 1'b1;
        at_neg();
        chk("sw_req2",   {31'b0, mem_req},     32'd1);
        tick();
        mem_ack = 1'b0;
        at_neg();
        chk("sw_ready",  {31'b0, st_ready},    32'd1);
        chk("sw_req_off",{31'b0, mem_req},     32'd0);
        tick();

        // SB 0xAABBCCDD -> 0x203, immediate ack
        issue(2'b10, 32'h0000_0203, 32'hAABB_CCDD);
        mem_ack = 1'b1;
        at_neg();
        chk("sb_be",    {28'b0, mem_byteen}, 32'h8);
        chk("sb_wdata", mem_wdata,           32'hDDDD_DDDD);
        chk("sb_addr",  mem_addr,            32'h0000_0200);
        tick();
        mem_ack = 1'b0;
        at_neg();
        chk("sb_single", {31'b0, mem_req}, 32'd0);
        tick();

        // SH 0xBEEF -> 0x102
        issue(2'b01, 32'h0000_0102, 32'h0000_BEEF);
        mem_ack = 1'b1;
        at_neg();
        chk("sh_be",    {28'b0, mem_byteen}, 32'hC);
        chk("sh_wdata", mem_wdata,           32'hBEEF_BEEF);
        tick();
        mem_ack = 1'b0;
        tick();

        // Illegal stores
        issue(2'b00, 32'h0000_0102, 32'h1);
        at_neg();
        chk("ill_sw_mis",  {31'b0, exc_ades}, 32'd1);
        chk("ill_sw_req",  {31'b0, mem_req},  32'd0);
        chk("ill_sw_rdy",  {31'b0, st_ready}, 32'd1);
        tick();
        at_neg();
        chk("ill_pulse_end", {31'b0, exc_ades}, 32'd0);
        tick();
        issue(2'b01, 32'h0000_7F04, 32'h2);
        at_neg();
        chk("ill_sh_tmr",  {31'b0, exc_ades}, 32'd1);
        tick();
        issue(2'b00, 32'h0000_7F08, 32'h3);
        at_neg();
        chk("ill_count",   {31'b0, exc_ades}, 32'd1);
        tick();
        issue(2'b00, 32'h0000_3000, 32'h4);
        at_neg();
        chk("ill_range",   {31'b0, exc_ades}, 32'd1);
        chk("ill_range_rq",{31'b0, mem_req},  32'd0);
        tick();

        // Timeout without ack
        issue(2'b00, 32'h0000_0010, 32'h0BAD_F00D);
        for (int k = 1; k <= TIMEOUT; k++) begin
            at_neg();
            chk("to_req_held", {31'b0, mem_req}, 32'd1);
            chk("to_no_err",   {31'b0, bus_err}, 32'd0);
            tick();
        end
        at_neg();
        chk("to_bus_err", {31'b0, bus_err},  32'd1);
        chk("to_req_off", {31'b0, mem_req},  32'd0);
        chk("to_ready",   {31'b0, st_ready}, 32'd1);
        tick();
        at_neg();
        chk("to_pulse_end", {31'b0, bus_err}, 32'd0);
        tick();

        // Ack on the last permitted cycle wins over the timeout
        issue(2'b00, 32'h0000_0014, 32'h0000_1111);
        for (int k = 1; k < TIMEOUT; k++) tick();
        mem_ack = 1'b1;
        at_neg();
        chk("late_ack_req", {31'b0, mem_req}, 32'd1);
        tick();
        mem_ack = 1'b0;
        at_neg();
        chk("late_ack_noerr", {31'b0, bus_err}, 32'd0);
        chk("late_ack_rdy",   {31'b0, st_ready}, 32'd1);
        tick();
        at_neg();
        chk("late_ack_noerr2", {31'b0, bus_err}, 32'd0);
        tick();

        // Stall while busy; the held request is taken in the first idle cycle
        issue(2'b00, 32'h0000_0200, 32'hAAAA_0001);
        st_valid = 1'b1;
        st_type  = 2'b00;
        st_addr  = 32'h0000_0204;
        st_data  = 32'hBBBB_0002;
        at_neg();
        chk("stall_hi",     {31'b0, stall}, 32'd1);
        chk("stall_hold_d", mem_wdata,      32'hAAAA_0001);
        tick();
        mem_ack = 1'b1;
        at_neg();
        chk("stall_ack_cyc", {31'b0, st_ready}, 32'd0);
        tick();
        mem_ack = 1'b0;
        at_neg();
        chk("stall_idle_rdy", {31'b0, st_ready}, 32'd1);
        chk("stall_idle_lo",  {31'b0, stall},    32'd0);
        tick();
        st_valid = 1'b0;
        at_neg();
        chk("stall_next_addr", mem_addr,  32'h0000_0204);
        chk("stall_next_data", mem_wdata, 32'hBBBB_0002);
        ack_after(0);

        // Reset during the 3rd request cycle
        issue(2'b10, 32'h0000_0041, 32'h0000_0077);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        at_neg();
        chk("rr_req",   {31'b0, mem_req},      32'd0);
        chk("rr_ready", {31'b0, st_ready},     32'd1);
        chk("rr_addr",  mem_addr,              32'd0);
        chk("rr_wdata", mem_wdata,             32'd0);
        chk("rr_be",    {28'b0, mem_byteen},   32'd0);
        chk("rr_err",   {31'b0, bus_err},      32'd0);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        at_neg();
        chk("rr_ack_ign_req", {31'b0, mem_req},  32'd0);
        chk("rr_ack_ign_rdy", {31'b0, st_ready}, 32'd1);
        tick();

        // Address-map and packing table
        vecs[0]  = '{2'b10, 32'h0000_2FFF, 32'h1122_3344, 1'b1, 4'b1000};
        vecs[1]  = '{2'b01, 32'h0000_7F00, 32'h0000_0001, 1'b0, 4'b0000};
        vecs[2]  = '{2'b00, 32'h0000_7F04, 32'hCAFE_F00D, 1'b1, 4'b1111};
        vecs[3]  = '{2'b00, 32'h0000_7F18, 32'h0000_0002, 1'b0, 4'b0000};
        vecs[4]  = '{2'b00, 32'h0000_7F1C, 32'h0000_0003, 1'b0, 4'b0000};
        vecs[5]  = '{2'b00, 32'h0000_7F0C, 32'h0000_0004, 1'b0, 4'b0000};
        vecs[6]  = '{2'b10, 32'h0000_0000, 32'h0000_0055, 1'b1, 4'b0001};
        vecs[7]  = '{2'b11, 32'h0000_0100, 32'h0000_0005, 1'b0, 4'b0000};
        vecs[8]  = '{2'b01, 32'h0000_7F12, 32'h0000_0006, 1'b0, 4'b0000};
        vecs[9]  = '{2'b00, 32'h0000_7F10, 32'h0102_0304, 1'b1, 4'b1111};
        vecs[10] = '{2'b01, 32'h0000_2FFE, 32'h1234_ABCD, 1'b1, 4'b1100};
        vecs[11] = '{2'b10, 32'h0000_7EFF, 32'h0000_0007, 1'b0, 4'b0000};
        foreach (vecs[i]) begin
            issue(vecs[i].t, vecs[i].a, vecs[i].d);
            at_neg();
            if (vecs[i].ok) begin
                chk("tbl_req", {31'b0, mem_req},     32'd1);
                chk("tbl_be",  {28'b0, mem_byteen},  {28'b0, vecs[i].be});
                ack_after(i % 3);
            end else begin
                chk("tbl_ades", {31'b0, exc_ades}, 32'd1);
                chk("tbl_noreq",{31'b0, mem_req},  32'd0);
                tick();
            end
        end

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
